// File: rtl/tt_seq_alu.sv
// Multi-cycle ALU with valid/ready handshake, internal accumulator and a
// WIDTH-cycle shift-add multiplier. Single-cycle ops complete on the accept edge.
module tt_seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    input  logic [1:0]           inmode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [RW-1:0]    mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [RW-1:0]    prod_reg;
    logic [CW-1:0]    cnt_reg;
    logic [RW-1:0]    result_reg;
    logic             carry_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [RW-1:0]    alu_res;
    logic             alu_carry;
    logic [RW-1:0]    mul_sum;

    // Operand sourcing: the accumulator can stand in for either operand.
    always_comb begin
        op_a = a;
        op_b = b;
        case (inmode)
            2'b01:   op_a = acc_reg;
            2'b10:   op_b = acc_reg;
            default: ;
        endcase
    end

    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = RW'(sum[WIDTH-1:0]);
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (A < B).
                alu_res   = RW'(diff[WIDTH-1:0]);
                alu_carry = diff[WIDTH];
            end
            OP_AND:  alu_res = RW'(op_a & op_b);
            OP_OR:   alu_res = RW'(op_a | op_b);
            OP_XOR:  alu_res = RW'(op_a ^ op_b);
            // Shifting by the whole of B lets any amount >= 2*WIDTH flush to zero.
            OP_SHL:  alu_res = RW'(op_a) << op_b;
            OP_SLT:  alu_res = diff[WIDTH] ? RW'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    assign mul_sum = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (inmode == 2'b11) begin
                            acc_reg <= '0;
                        end
                        if (opcode == OP_MUL) begin
                            mcand_reg  <= RW'(op_a);
                            mplier_reg <= op_b;
                            prod_reg   <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= ST_MUL;
                        end else begin
                            result_reg <= alu_res;
                            carry_reg  <= alu_carry;
                            zero_reg   <= (alu_res == '0);
                            acc_reg    <= alu_res[WIDTH-1:0];
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    prod_reg   <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        result_reg <= mul_sum;
                        carry_reg  <= 1'b0;
                        zero_reg   <= (mul_sum == '0);
                        acc_reg    <= mul_sum[WIDTH-1:0];
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_tt_seq_alu.sv
// Self-checking bench for tt_seq_alu: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against an arithmetic model.
module tb_tt_seq_alu;

    localparam int W  = 4;
    localparam int M  = 1 << W;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_s = '0;
    logic [W-1:0]  b_s = '0;
    logic [2:0]    opcode_s = '0;
    logic [1:0]    inmode_s = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] result;
    logic          carry;
    logic          zero;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    int acc_model = 0;

    tt_seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .opcode    (opcode_s),
        .inmode    (inmode_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
        int im;
        int r;
        int c;
        int hold;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic on integers, truncated to the result width.
    function automatic void model(input int av, input int bv, input int op,
                                  output int r, output int c);
        int s;
        r = 0;
        c = 0;
        case (op)
            0: begin s = av + bv; r = s % M; c = s / M; end
            1: begin r = (av - bv + M) % M; c = (av < bv) ? 1 : 0; end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = av * bv;
            6: r = (bv >= RW) ? 0 : ((av << bv) % (M * M));
            default: r = (av < bv) ? 1 : 0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_model = 0;
    endtask

    // Called at posedge+1 with the DUT idle. Holds the result for 'hold'
    // cycles with a junk transaction offered before releasing it.
    task automatic run_txn(input string name, input int av, input int bv, input int op,
                           input int im, input int exp_r, input int exp_c, input int hold);
        int lat;
        int exp_lat;
        int busy_ok;
        int stable_ok;
        logic [RW-1:0] r0;
        logic c0;
        logic z0;
        txn_no++;
        check({name, " in_ready idle"}, int'(in_ready), 1);
        a_s = W'(av);
        b_s = W'(bv);
        opcode_s = 3'(op);
        inmode_s = 2'(im);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // out_valid sampled high at edge N+lat, accept being edge N.
        lat = 1;
        busy_ok = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (op == 5) ? W + 1 : 1;
        check({name, " out_valid"}, int'(out_valid), 1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " in_ready busy"}, busy_ok, 1);
        check({name, " result"}, int'(result), exp_r);
        check({name, " carry"}, int'(carry), exp_c);
        check({name, " zero"}, int'(zero), (exp_r == 0) ? 1 : 0);
        if (hold > 0) begin
            r0 = result;
            c0 = carry;
            z0 = zero;
            stable_ok = 1;
            in_valid = 1'b1;
            a_s = W'($urandom);
            b_s = W'($urandom);
            opcode_s = 3'($urandom);
            inmode_s = 2'($urandom);
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || result != r0 || carry != c0 || zero != z0)
                    stable_ok = 0;
            end
            in_valid = 1'b0;
            check({name, " held stable"}, stable_ok, 1);
        end
        out_ready = 1'b1;
        check({name, " in_ready handoff"}, int'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid drop"}, int'(out_valid), 0);
        $display("txn %0d %s: op=%0d im=%0d a=%0d b=%0d -> result=%0d carry=%0d zero=%0d lat=%0d (exp %0d/%0d)",
                 txn_no, name, op, im, av, bv, result, carry, zero, lat, exp_r, exp_c);
    endtask

    initial begin
        // {a, b, op, inmode, result, carry, hold}; W=4, applied in order from reset.
        vecs[0]  = '{9, 8, 0, 0, 1, 1, 0};
        vecs[1]  = '{3, 5, 1, 0, 14, 1, 0};
        vecs[2]  = '{15, 15, 5, 0, 225, 0, 2};
        vecs[3]  = '{3, 4, 0, 0, 7, 0, 0};
        vecs[4]  = '{13, 2, 0, 1, 9, 0, 0};
        vecs[5]  = '{1, 1, 0, 3, 2, 0, 1};
        vecs[6]  = '{5, 11, 0, 2, 7, 0, 0};
        vecs[7]  = '{1, 8, 6, 0, 0, 0, 0};
        vecs[8]  = '{2, 7, 7, 0, 1, 0, 0};
        vecs[9]  = '{10, 10, 4, 0, 0, 0, 0};
        vecs[10] = '{12, 10, 2, 0, 8, 0, 0};
        vecs[11] = '{12, 3, 3, 0, 15, 0, 0};
        vecs[12] = '{6, 3, 5, 1, 45, 0, 0};
        vecs[13] = '{2, 9, 1, 2, 5, 1, 0};
        vecs[14] = '{3, 5, 6, 0, 96, 0, 0};
        vecs[15] = '{7, 2, 7, 0, 0, 0, 0};
        vecs[16] = '{15, 15, 0, 0, 14, 1, 0};

        do_reset();
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset result", int'(result), 0);
        check("reset carry", int'(carry), 0);
        check("reset zero", int'(zero), 0);

        for (int i = 0; i < 17; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].im,
                    vecs[i].r, vecs[i].c, vecs[i].hold);
        end

        // Backpressure: 10 held cycles with junk offered, then prove acc untouched.
        run_txn("bp_mul", 6, 7, 5, 0, 42, 0, 10);
        run_txn("bp_acc", 0, 0, 0, 1, 10, 0, 0);

        // Reset in the middle of a multiply.
        a_s = 4'd15;
        b_s = 4'd15;
        opcode_s = 3'd5;
        inmode_s = 2'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midmul out_valid", int'(out_valid), 0);
        check("midmul in_ready", int'(in_ready), 1);
        check("midmul result", int'(result), 0);
        check("midmul carry", int'(carry), 0);
        check("midmul zero", int'(zero), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc_model = 0;
        run_txn("midmul_acc", 9, 0, 0, 1, 0, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            int av, bv, op, im, ea, eb, er, ec;
            av = int'($urandom_range(0, M - 1));
            bv = int'($urandom_range(0, M - 1));
            op = int'($urandom_range(0, 7));
            im = int'($urandom_range(0, 3));
            ea = (im == 1) ? acc_model : av;
            eb = (im == 2) ? acc_model : bv;
            model(ea, eb, op, er, ec);
            acc_model = er % M;
            run_txn($sformatf("rnd%0d", t), av, bv, op, im, er, ec,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
